// File: rtl/coef_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coef_bank_pkg
//  Description : Shared types and sizing helpers for the double-buffered
//                FIR coefficient bank loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package coef_bank_pkg;

   // Loader FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Number of words loaded when the bank is symmetric (centre tap shared)
   function automatic int calc_nh(input int ntaps);
      return (ntaps + 1) / 2;
   endfunction

   // Width of a counter able to hold 0..ntaps inclusive
   function automatic int calc_cntw(input int ntaps);
      return $clog2(ntaps + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/coef_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : coef_regfile
//  Description : NTAPS x CW shadow/active register pair. Single write port
//                into the shadow bank with optional mirrored write to the
//                symmetric tap; a commit strobe copies every shadow entry
//                into the active bank on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module coef_regfile #(
   parameter int NTAPS = 16,
   parameter int CW    = 12,
   parameter int AW    = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [AW-1:0]       addr,
   input  logic [CW-1:0]       data,
   input  logic                mirror,
   input  logic                commit,
   output logic [NTAPS*CW-1:0] active_flat
);

   generate
      for (genvar k = 0; k < NTAPS; k++) begin : g_tap
         logic [CW-1:0] shadow;
         logic [CW-1:0] active;
         logic          hit;

         // A tap is written when addressed directly or as the mirror image
         assign hit = we && ((addr == AW'(k)) ||
                             (mirror && (addr == AW'(NTAPS - 1 - k))));

         // Shadow capture and atomic shadow-to-active copy
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow <= '0;
               active <= '0;
            end else begin
               if (hit) begin
                  shadow <= data;
               end
               if (commit) begin
                  active <= shadow;
               end
            end
         end

         assign active_flat[k*CW +: CW] = active;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/coef_bank_loader.sv
`default_nettype none
// ============================================================================
//  Module      : coef_bank_loader
//  Description : Double-buffered FIR coefficient bank. Coefficients arrive
//                serially into a shadow bank and are committed atomically to
//                the active bank, so the FIR keeps using the previous set
//                while a new one loads.
//  Options     : COEF_SYM_EN - load only (NTAPS+1)/2 words and mirror each
//                into the symmetric tap.
//  Revision    : 1.0 - initial release
// ============================================================================
module coef_bank_loader
   import coef_bank_pkg::*;
#(
   parameter  int NTAPS = 16,
   parameter  int CW    = 12,
   localparam int CNTW  = calc_cntw(NTAPS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CW-1:0]       coef_i,
   input  logic                coef_valid_i,
   input  logic                en_recepcion_i,
   input  logic                reload_i,
   output logic [NTAPS*CW-1:0] coefs_o,
   output logic [CNTW-1:0]     load_cnt_o,
   output logic                busy_o,
   output logic                fin_block_coef_o,
   output logic                loaded_o,
   output logic                ovf_o
);

`ifdef COEF_SYM_EN
   localparam int   LIMIT  = calc_nh(NTAPS);
   localparam logic MIRROR = 1'b1;
`else
   localparam int   LIMIT  = NTAPS;
   localparam logic MIRROR = 1'b0;
`endif

   // Counter value at which the next accepted word completes the set
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LIMIT - 1);

   state_t          state, state_nx;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic            ovf, ovf_nx;
   logic            loaded, loaded_nx;
   logic            fin, fin_nx;
   logic            accepted;
   logic            we;
   logic            commit;

   assign accepted = coef_valid_i & en_recepcion_i;
   assign commit   = (state == COMMIT);

   // State and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         ovf    <= 1'b0;
         loaded <= 1'b0;
         fin    <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         ovf    <= ovf_nx;
         loaded <= loaded_nx;
         fin    <= fin_nx;
      end
   end

   // Next-state, counter and shadow write control; reload beats a word
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      ovf_nx    = ovf;
      loaded_nx = loaded;
      fin_nx    = 1'b0;
      we        = 1'b0;
      case (state)
         IDLE, LOAD: begin
            // IDLE always holds cnt==0, so an implicit start writes tap 0
            if (reload_i) begin
               state_nx = LOAD;
               cnt_nx   = '0;
            end else if (accepted) begin
               we       = 1'b1;
               cnt_nx   = cnt + CNTW'(1);
               state_nx = (cnt == CNT_LAST) ? COMMIT : LOAD;
            end
         end
         COMMIT: begin
            // fin and coefs_o both become visible on this edge
            fin_nx    = 1'b1;
            loaded_nx = 1'b1;
            state_nx  = DONE;
            if (accepted) begin
               ovf_nx = 1'b1;
            end
         end
         DONE: begin
            if (reload_i) begin
               state_nx = LOAD;
               cnt_nx   = '0;
               ovf_nx   = 1'b0;
            end else if (accepted) begin
               ovf_nx = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   coef_regfile #(
      .NTAPS (NTAPS),
      .CW    (CW),
      .AW    (CNTW)
   ) u_regfile (
      .clk         (clk),
      .rst_n       (rst_n),
      .we          (we),
      .addr        (cnt),
      .data        (coef_i),
      .mirror      (MIRROR),
      .commit      (commit),
      .active_flat (coefs_o)
   );

   assign load_cnt_o       = cnt;
   assign busy_o           = (state == LOAD);
   assign fin_block_coef_o = fin;
   assign loaded_o         = loaded;
   assign ovf_o            = ovf;

endmodule
`default_nettype wire
